writeback_arbiter: RTL and testbench

//  Producer side of the register-file write port. Merges ALU and load-unit results over valid/ready

---
 rtl/rv32_isa_pkg.sv | 16 +
 rtl/reg_scoreboard.sv | 46 ++++
 rtl/writeback_arbiter.sv | 112 +++++++++++
 tb/tb_writeback_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32_isa_pkg.sv
// rtl/rv32_isa_pkg.sv - RV32 register-file widths, address type and write-back source encoding
package rv32_isa;

  localparam int RegWidth     = 32;
  localparam int RegAddrWidth = 5;

  typedef logic [RegAddrWidth-1:0] reg_addr_t;

  // Which producer owns the write port this cycle
  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_MEM  = 2'd2
  } wb_src_e;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - pending-destination bits with RAW busy queries and WAW issue stall
module reg_scoreboard
  import rv32_isa::*;
#(
  parameter int NRegs = 32
) (
  input  logic                    iClk,
  input  logic                    nRst,
  input  logic                    issue_valid,
  input  logic [RegAddrWidth-1:0] issue_rd,
  output logic                    issue_stall,
  input  logic                    clr_en,
  input  logic [RegAddrWidth-1:0] clr_addr,
  input  logic [RegAddrWidth-1:0] rs1_addr,
  input  logic [RegAddrWidth-1:0] rs2_addr,
  output logic                    rs1_busy,
  output logic                    rs2_busy
);

  logic [NRegs-1:0] pending_q;
  logic [NRegs-1:0] pending_d;
  logic             set_en;

  // Queries look at registered state only; a same-edge write is not bypassed
  always_comb begin
    issue_stall = (issue_rd != '0) && pending_q[issue_rd];
    rs1_busy    = (rs1_addr != '0) && pending_q[rs1_addr];
    rs2_busy    = (rs2_addr != '0) && pending_q[rs2_addr];
    set_en      = issue_valid && !issue_stall && (issue_rd != '0);
  end

  // Clear on write-back, then set on issue so a new owner of the same register wins
  always_comb begin
    pending_d = pending_q;
    if (clr_en) pending_d[clr_addr] = 1'b0;
    if (set_en) pending_d[issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Pending-bit register
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) pending_q <= '0;
    else       pending_q <= pending_d;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - ALU/load write-port arbiter with starvation guard and pending scoreboard
module writeback_arbiter
  import rv32_isa::*;
#(
  parameter int NRegs       = 32,
  parameter int StarveLimit = 2
) (
  input  logic                    iClk,
  input  logic                    nRst,
  input  logic                    iIssueValid,
  input  logic [RegAddrWidth-1:0] iIssueRd,
  output logic                    oIssueStall,
  input  logic [RegAddrWidth-1:0] iRs1Addr,
  input  logic [RegAddrWidth-1:0] iRs2Addr,
  output logic                    oRs1Busy,
  output logic                    oRs2Busy,
  input  logic                    iAluValid,
  output logic                    oAluReady,
  input  logic [RegAddrWidth-1:0] iAluRd,
  input  logic [RegWidth-1:0]     iAluData,
  input  logic                    iMemValid,
  output logic                    oMemReady,
  input  logic [RegAddrWidth-1:0] iMemRd,
  input  logic [RegWidth-1:0]     iMemData,
  output logic                    oWriteEn,
  output logic [RegAddrWidth-1:0] oAddr_Rd,
  output logic [RegWidth-1:0]     oRd
);

  localparam int CntW = (StarveLimit < 1) ? 1 : $clog2(StarveLimit + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(StarveLimit);

  logic [CntW-1:0]         starve_q, starve_d;
  logic                    wr_en_q, wr_en_d;
  logic [RegAddrWidth-1:0] wr_addr_q, wr_addr_d;
  logic [RegWidth-1:0]     wr_data_q, wr_data_d;
  logic                    force_alu;
  wb_src_e                 grant;

  // Loads win by default; a starved ALU is pushed ahead once the limit is reached
  always_comb begin
    force_alu = (starve_q >= StarveMax);
    oMemReady = !force_alu;
    oAluReady = !iMemValid || force_alu;
    grant     = WB_NONE;
    if (iMemValid && oMemReady)      grant = WB_MEM;
    else if (iAluValid && oAluReady) grant = WB_ALU;
  end

  // Count consecutive refused ALU offers; any accept or idle ALU restarts the count
  always_comb begin
    starve_d = starve_q;
    if (!iAluValid || (grant == WB_ALU)) starve_d = '0;
    else if (starve_q != StarveMax)      starve_d = starve_q + 1'b1;
  end

  // Stage the granted result for the write port; x0 results are swallowed
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (grant)
      WB_MEM: if (iMemRd != '0) begin
        wr_en_d   = 1'b1;
        wr_addr_d = iMemRd;
        wr_data_d = iMemData;
      end
      WB_ALU: if (iAluRd != '0) begin
        wr_en_d   = 1'b1;
        wr_addr_d = iAluRd;
        wr_data_d = iAluData;
      end
      default: ;
    endcase
  end

  // Starve counter and write-port register
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      starve_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      starve_q  <= starve_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign oWriteEn = wr_en_q;
  assign oAddr_Rd = wr_addr_q;
  assign oRd      = wr_data_q;

  reg_scoreboard #(
    .NRegs(NRegs)
  ) u_scoreboard (
    .iClk       (iClk),
    .nRst       (nRst),
    .issue_valid(iIssueValid),
    .issue_rd   (iIssueRd),
    .issue_stall(oIssueStall),
    .clr_en     (wr_en_q),
    .clr_addr   (wr_addr_q),
    .rs1_addr   (iRs1Addr),
    .rs2_addr   (iRs2Addr),
    .rs1_busy   (oRs1Busy),
    .rs2_busy   (oRs2Busy)
  );

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - scoreboard bench for writeback_arbiter
module tb_writeback_arbiter;

  logic        iClk = 1'b0;
  logic        nRst;
  logic        iIssueValid;
  logic [4:0]  iIssueRd;
  logic        oIssueStall;
  logic [4:0]  iRs1Addr, iRs2Addr;
  logic        oRs1Busy, oRs2Busy;
  logic        iAluValid, oAluReady;
  logic [4:0]  iAluRd;
  logic [31:0] iAluData;
  logic        iMemValid, oMemReady;
  logic [4:0]  iMemRd;
  logic [31:0] iMemData;
  logic        oWriteEn;
  logic [4:0]  oAddr_Rd;
  logic [31:0] oRd;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  always #5 iClk = ~iClk;

  writeback_arbiter #(.NRegs(32), .StarveLimit(2)) dut (
    .iClk(iClk), .nRst(nRst),
    .iIssueValid(iIssueValid), .iIssueRd(iIssueRd), .oIssueStall(oIssueStall),
    .iRs1Addr(iRs1Addr), .iRs2Addr(iRs2Addr), .oRs1Busy(oRs1Busy), .oRs2Busy(oRs2Busy),
    .iAluValid(iAluValid), .oAluReady(oAluReady), .iAluRd(iAluRd), .iAluData(iAluData),
    .iMemValid(iMemValid), .oMemReady(oMemReady), .iMemRd(iMemRd), .iMemData(iMemData),
    .oWriteEn(oWriteEn), .oAddr_Rd(oAddr_Rd), .oRd(oRd)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    iIssueValid = 1'b0; iIssueRd = '0;
    iAluValid = 1'b0; iAluRd = '0; iAluData = '0;
    iMemValid = 1'b0; iMemRd = '0; iMemData = '0;
  endtask

  task automatic tick();
    @(negedge iClk);
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    iAluValid = 1'b1; iAluRd = rd; iAluData = d;
  endtask

  task automatic mem(input logic [4:0] rd, input logic [31:0] d);
    iMemValid = 1'b1; iMemRd = rd; iMemData = d;
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] d);
    wr_t w;
    w.addr = rd; w.data = d;
    exp_q.push_back(w);
  endtask

  // Monitor: every write-port pulse must match the oldest expected write
  always @(negedge iClk) begin
    if (oWriteEn) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {27'd0, oAddr_Rd}, 32'd0);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("wr_addr", {27'd0, oAddr_Rd}, {27'd0, w.addr});
        check("wr_data", oRd, w.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    nRst = 1'b0;
    idle();
    iRs1Addr = '0; iRs2Addr = '0;
    tick(); tick();
    #1;
    check("rst_we",   {31'd0, oWriteEn}, 32'd0);
    check("rst_addr", {27'd0, oAddr_Rd}, 32'd0);
    check("rst_data", oRd, 32'd0);
    nRst = 1'b1;
    tick();

    // Single ALU result
    alu(5'd5, 32'hDEADBEEF);
    #1 check("alu_ready_single", {31'd0, oAluReady}, 32'd1);
    push(5'd5, 32'hDEADBEEF);
    tick(); idle(); tick();

    // Collision: load wins twice, ALU forced on the third cycle
    alu(5'd3, 32'h33); mem(5'd4, 32'h44);
    #1 check("col1_mem_ready", {31'd0, oMemReady}, 32'd1);
    check("col1_alu_ready", {31'd0, oAluReady}, 32'd0);
    push(5'd4, 32'h44);
    tick(); mem(5'd6, 32'h66);
    #1 check("col2_alu_ready", {31'd0, oAluReady}, 32'd0);
    push(5'd6, 32'h66);
    tick(); mem(5'd8, 32'h88);
    #1 check("col3_mem_ready", {31'd0, oMemReady}, 32'd0);
    check("col3_alu_ready", {31'd0, oAluReady}, 32'd1);
    push(5'd3, 32'h33);
    tick(); iAluValid = 1'b0;
    #1 check("col4_mem_ready", {31'd0, oMemReady}, 32'd1);
    push(5'd8, 32'h88);
    tick(); idle(); tick();

    // Scoreboard: issue, WAW stall, clear after write, set wins on clear edge
    iRs1Addr = 5'd7; iRs2Addr = 5'd7;
    iIssueValid = 1'b1; iIssueRd = 5'd7;
    #1 check("sb_issue_stall0", {31'd0, oIssueStall}, 32'd0);
    check("sb_no_bypass", {31'd0, oRs1Busy}, 32'd0);
    tick();
    #1 check("sb_rs1_busy", {31'd0, oRs1Busy}, 32'd1);
    check("sb_rs2_busy", {31'd0, oRs2Busy}, 32'd1);
    check("sb_waw_stall", {31'd0, oIssueStall}, 32'd1);
    tick(); iIssueValid = 1'b0;
    alu(5'd7, 32'h77);
    #1 check("sb_alu_ready", {31'd0, oAluReady}, 32'd1);
    push(5'd7, 32'h77);
    tick(); idle();
    #1 check("sb_busy_during_we", {31'd0, oRs1Busy}, 32'd1);
    tick();
    #1 check("sb_busy_cleared", {31'd0, oRs1Busy}, 32'd0);
    alu(5'd7, 32'h78);
    push(5'd7, 32'h78);
    tick(); idle();
    iIssueValid = 1'b1; iIssueRd = 5'd7;
    #1 check("sb_clear_edge_stall", {31'd0, oIssueStall}, 32'd0);
    tick(); iIssueValid = 1'b0;
    #1 check("sb_set_wins", {31'd0, oRs1Busy}, 32'd1);
    tick();

    // x0: never pending, result accepted but not written
    iRs1Addr = 5'd0; iRs2Addr = 5'd0;
    iIssueValid = 1'b1; iIssueRd = 5'd0;
    #1 check("x0_stall", {31'd0, oIssueStall}, 32'd0);
    tick(); iIssueValid = 1'b0;
    #1 check("x0_busy", {31'd0, oRs1Busy}, 32'd0);
    alu(5'd0, 32'h1234);
    #1 check("x0_alu_ready", {31'd0, oAluReady}, 32'd1);
    tick(); idle();
    #1 check("x0_no_we", {31'd0, oWriteEn}, 32'd0);
    tick();

    // Back-to-back loads
    for (int i = 1; i <= 3; i++) begin
      mem(5'(i), 32'hA000_0000 + 32'(i));
      #1 check("b2b_mem_ready", {31'd0, oMemReady}, 32'd1);
      push(5'(i), 32'hA000_0000 + 32'(i));
      tick();
    end
    idle(); tick(); tick();

    // Mid-cycle reset with a forced ALU and a pending register
    iRs1Addr = 5'd9;
    iIssueValid = 1'b1; iIssueRd = 5'd9;
    alu(5'd10, 32'hAA); mem(5'd0, 32'h55);
    tick(); iIssueValid = 1'b0;
    tick();
    #1 check("pre_rst_force", {31'd0, oMemReady}, 32'd0);
    check("pre_rst_busy", {31'd0, oRs1Busy}, 32'd1);
    check("pre_rst_addr", {27'd0, oAddr_Rd}, 32'd3);
    nRst = 1'b0;
    #1 check("mid_rst_we", {31'd0, oWriteEn}, 32'd0);
    check("mid_rst_addr", {27'd0, oAddr_Rd}, 32'd0);
    check("mid_rst_data", oRd, 32'd0);
    check("mid_rst_busy", {31'd0, oRs1Busy}, 32'd0);
    check("mid_rst_mem_ready", {31'd0, oMemReady}, 32'd1);
    check("mid_rst_alu_ready", {31'd0, oAluReady}, 32'd0);
    tick(); idle();
    nRst = 1'b1;
    tick();
    alu(5'd11, 32'hCAFEF00D);
    push(5'd11, 32'hCAFEF00D);
    tick(); idle(); tick(); tick();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
